// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   EX-stage multiply/divide engine that owns the architectural HI/LO pair of
//   the 5-stage MIPS core.
//   - MULT/MULTU finish in one edge: the 64-bit product lands in HI/LO on the
//     accepting edge. busy never rises for a multiply.
//   - DIV/DIVU run an iterative restoring divider that retires
//     DIV_RADIX_BITS quotient bits per cycle. The sequence is: accept edge,
//     ITER cycles in DIV, then one cycle in FIX, where signs are applied and
//     HI/LO are written.
//   - MTHI/MTLO write src1 into HI/LO while the unit is idle.
//   - cancel (exception flush) aborts an in-flight divide and blocks any
//     same-cycle request in IDLE.
//
// Handshake: op_valid is a single-cycle request with no ready return. While
// busy is high the hazard unit keeps op_valid, mthi and mtlo low, and the
// unit ignores them if they arrive anyway. res_valid pulses for one cycle
// once a mul/div result is visible on hi/lo.
//
// Ports
//   clk        in   core clock, rising edge
//   resetn     in   asynchronous active-low reset
//   op_valid   in   EX holds a mul/div op and is not stalled
//   op         in   one-hot op: [0] MULT, [1] MULTU, [2] DIV, [3] DIVU
//   src1       in   rs operand (multiplicand / dividend / MTHI-MTLO data)
//   src2       in   rt operand (multiplier / divisor)
//   mthi       in   write src1 into HI
//   mtlo       in   write src1 into LO
//   cancel     in   exception flush
//   busy       out  divide in flight (state != IDLE)
//   res_valid  out  one-cycle pulse after a mul/div result lands in HI/LO
//   hi, lo     out  HI/LO registers
//   stateDbg   out  current FSM state, for debug and checkers
//
// DIV_RADIX_BITS: quotient bits per iteration. Legal values are 1 and 2.
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int DIV_RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        cancel,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  stateDbg
);

  localparam int ITER = 32 / DIV_RADIX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT       state;
  stateT       nextState;

  // Divider working state
  logic [5:0]  cnt;
  logic [31:0] remReg;       // partial remainder, always < divisor
  logic [31:0] quoReg;       // dividend bits shift out, quotient bits shift in
  logic [31:0] divisorReg;   // |divisor|
  logic [31:0] dividendReg;  // raw dividend, returned in HI on divide by zero
  logic        negQuo;
  logic        negRem;
  logic        divZero;

  // Per-cycle control decoded by the FSM
  logic        mulFire;
  logic        divFire;
  logic        fixWrite;
  logic        mtHiFire;
  logic        mtLoFire;

  // -------------------------------------------------------------------------
  // Operand preparation
  // -------------------------------------------------------------------------
  logic        divSigned;
  logic [31:0] absSrc1;
  logic [31:0] absSrc2;
  logic [63:0] mulA;
  logic [63:0] mulB;
  logic [63:0] product;

  assign divSigned = op[2];
  // -0x80000000 wraps to 0x80000000, which is still the correct unsigned
  // magnitude, so the most negative dividend needs no special case.
  assign absSrc1 = (divSigned && src1[31]) ? (32'd0 - src1) : src1;
  assign absSrc2 = (divSigned && src2[31]) ? (32'd0 - src2) : src2;

  // Sign- or zero-extend both operands to 64 bits. The low 64 bits of the
  // 64x64 product are then the correct result for MULT and for MULTU alike.
  assign mulA    = {{32{op[0] & src1[31]}}, src1};
  assign mulB    = {{32{op[0] & src2[31]}}, src2};
  assign product = mulA * mulB;

  // -------------------------------------------------------------------------
  // One restoring-division step: shift the next dividend bit into the
  // remainder, then subtract the divisor if it fits.
  // Result layout: {newRemainder, newQuotientShiftRegister}.
  // -------------------------------------------------------------------------
  function automatic logic [63:0] divStep(input logic [31:0] r,
                                          input logic [31:0] q,
                                          input logic [31:0] d);
    logic [32:0] shifted;
    shifted = {r, q[31]};
    if (shifted >= {1'b0, d}) begin
      divStep = {32'(shifted - {1'b0, d}), q[30:0], 1'b1};
    end else begin
      divStep = {shifted[31:0], q[30:0], 1'b0};
    end
  endfunction

  logic [31:0] stepRem;
  logic [31:0] stepQuo;

  always_comb begin
    stepRem = remReg;
    stepQuo = quoReg;
    for (int i = 0; i < DIV_RADIX_BITS; i++) begin
      {stepRem, stepQuo} = divStep(stepRem, stepQuo, divisorReg);
    end
  end

  // Final sign fix-up applied in FIX
  logic [31:0] finalQuo;
  logic [31:0] finalRem;

  assign finalQuo = negQuo ? (32'd0 - quoReg) : quoReg;
  assign finalRem = negRem ? (32'd0 - remReg) : remReg;

  // -------------------------------------------------------------------------
  // FSM: next state and per-cycle control
  // -------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    mulFire   = 1'b0;
    divFire   = 1'b0;
    fixWrite  = 1'b0;
    mtHiFire  = 1'b0;
    mtLoFire  = 1'b0;
    case (state)
      IDLE: begin
        // cancel blocks everything; an accepted op drops same-cycle MTHI/MTLO
        if (!cancel) begin
          if (op_valid && (op[0] || op[1])) begin
            mulFire = 1'b1;
          end else if (op_valid && (op[2] || op[3])) begin
            divFire   = 1'b1;
            nextState = DIV;
          end else begin
            mtHiFire = mthi;
            mtLoFire = mtlo;
          end
        end
      end
      DIV: begin
        if (cancel) begin
          nextState = IDLE;
        end else if (cnt == 6'd1) begin
          nextState = FIX;
        end
      end
      FIX: begin
        nextState = IDLE;
        if (!cancel) begin
          fixWrite = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  assign busy     = (state != IDLE);
  assign stateDbg = state;

  // -------------------------------------------------------------------------
  // Divider datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      remReg      <= '0;
      quoReg      <= '0;
      divisorReg  <= '0;
      dividendReg <= '0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      divZero     <= 1'b0;
    end else if (divFire) begin
      cnt         <= 6'(ITER);
      remReg      <= '0;
      quoReg      <= absSrc1;
      divisorReg  <= absSrc2;
      dividendReg <= src1;
      negQuo      <= divSigned & (src1[31] ^ src2[31]);
      negRem      <= divSigned & src1[31];
      divZero     <= (src2 == 32'd0);
    end else if (state == DIV && !cancel) begin
      cnt    <= cnt - 6'd1;
      remReg <= stepRem;
      quoReg <= stepQuo;
    end
  end

  // -------------------------------------------------------------------------
  // HI/LO and result pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi        <= '0;
      lo        <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= mulFire | fixWrite;
      if (mulFire) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end else if (fixWrite) begin
        // Divide by zero still runs the full latency but reports a fixed
        // all-ones quotient and hands the raw dividend back in HI.
        if (divZero) begin
          hi <= dividendReg;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= finalRem;
          lo <= finalQuo;
        end
      end else begin
        if (mtHiFire) hi <= src1;
        if (mtLoFire) lo <= src1;
      end
    end
  end

endmodule
